// File: rtl/fifo_axis_reader.sv
// Read side of the asymmetric data FIFO: pops DATA_W-bit words and streams them out as
// AXI-Stream packets of cntLimit beats. Optional first-beat tuser via FIFO_AXIS_READER_TUSER_EN.
module fifo_axis_reader #(
  parameter int DATA_W = 3,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  cntLimit,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
`ifdef FIFO_AXIS_READER_TUSER_EN
  output logic              m_axis_tuser,
`endif
  output logic              busy,
  output logic              done
);

  // Stream handshake: a beat transfers on a clk edge where tvalid & tready are both high;
  // once tvalid rises, tdata/tlast stay frozen until that edge.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  limit;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  tx_cnt;
  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        occ;
  logic              inflight;

  logic              pop;
  logic              push;
  logic              tx_at_last;
  logic              accept;
  logic [2:0]        fill;

  assign pop        = m_axis_tvalid & m_axis_tready;
  assign push       = inflight;
  assign tx_at_last = (tx_cnt == limit - CNT_W'(1));
  assign accept     = (state == S_IDLE) && start && (cntLimit != '0);
  // Words already committed to the skid buffer after this cycle's pop; a read is allowed only if it still fits.
  assign fill       = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_RUN;
      S_RUN:   if (pop && tx_at_last) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state == S_RUN);
    done          = (state == S_DONE);
    fifo_rd_en    = (state == S_RUN) && !fifo_empty && (rd_cnt < limit) && (fill < 3'd2);
    m_axis_tvalid = (occ != 2'd0);
    m_axis_tdata  = mem[rd_ptr];
    m_axis_tlast  = m_axis_tvalid && tx_at_last;
`ifdef FIFO_AXIS_READER_TUSER_EN
    m_axis_tuser  = m_axis_tvalid && (tx_cnt == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      limit    <= '0;
      rd_cnt   <= '0;
      tx_cnt   <= '0;
      mem[0]   <= '0;
      mem[1]   <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (accept) begin
        limit  <= cntLimit;
        rd_cnt <= '0;
        tx_cnt <= '0;
      end else begin
        if (fifo_rd_en) rd_cnt <= rd_cnt + CNT_W'(1);
        if (pop)        tx_cnt <= tx_cnt + CNT_W'(1);
      end
      if (push) begin
        mem[wr_ptr] <= fifo_dout;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: doc/fifo_axis_reader.md
Name: fifo_axis_reader

Overview:
- Read side of the asymmetric data FIFO; the wide word is written upstream and read out in 3-bit slices.
- Pops 3-bit words from a first-word-fall-through-disabled FIFO (standard read, 1-cycle latency) and presents them as an AXI-Stream master.
- Each `start` launches one packet of `cntLimit` beats, with `tlast` on the final beat.
- A 2-entry skid buffer decouples FIFO read latency from `tready` backpressure, giving full 1-beat/cycle throughput.

Parameters:
- DATA_W, 3, FIFO dout width and tdata width.
- CNT_W, 6, width of `cntLimit` and the internal beat counters.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  packet request; sampled only in IDLE.
- cntLimit  in  CNT_W  packet length in beats; latched when `start` is accepted.
- fifo_dout  in  DATA_W  FIFO read data; valid the cycle after `fifo_rd_en`.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe.
- m_axis_tdata  out  DATA_W  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  last beat of packet.
- busy  out  1  high while a packet is in progress.
- done  out  1  1-cycle pulse after the last beat transfers.

Behaviour:
- **Reset.** `rst` sampled high at a clk edge gives:
  - state=IDLE, buffer occupancy=0, in-flight flag=0, counters=0;
  - `fifo_rd_en`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `busy`=0, `done`=0.
  - Reset mid-packet aborts immediately; buffered or in-flight words are discarded. A FIFO read issued in the reset cycle is lost.
- **States: IDLE.**
  - `start`=1 and `cntLimit`!=0: latch limit, clear `rd_cnt` and `tx_cnt`, go to RUN.
  - `start` with `cntLimit`=0 is ignored and stays in IDLE with no `done`.
- **States: RUN.**
  - Reads and transmits until the handshake (tvalid&tready) with `tx_cnt`=limit-1.
  - That edge moves to DONE.
  - `start` is ignored in RUN.
- **States: DONE.**
  - One cycle with `done`=1, then IDLE.
  - `busy`=1 in RUN only.
- **Read issue.**
  - `fifo_rd_en` is combinational: RUN & !`fifo_empty` & (`rd_cnt` < limit) & (occupancy + inflight − pop < 2), where pop = tvalid & tready this cycle.
  - Never asserted when `fifo_empty`=1 or outside RUN.
  - Never reads more than the limit words per packet.
- **Capture.**
  - In-flight flag is a register of `fifo_rd_en`.
  - When it is set, `fifo_dout` is written into the buffer tail at the next edge.
  - Push and pop in the same cycle are both honoured.
- **Output.**
  - `m_axis_tvalid` = occupancy!=0; `m_axis_tdata` = buffer head.
  - `m_axis_tlast` = tvalid & (`tx_cnt` = limit−1).
  - tdata, tvalid and tlast are held stable while tvalid & !tready.
- **Latency.** `start` sampled at edge E0 gives `fifo_rd_en` during the cycle after E0, FIFO samples at E1, capture at E2, and `m_axis_tvalid` high after E2 (2 edges).
- **Throughput.** With `tready`=1 and the FIFO non-empty, 1 beat/cycle.
- **Starvation.** FIFO empty mid-packet produces tvalid gaps only; the packet resumes when data arrives.
- **Width rules.**
  - Counters are CNT_W bits; the maximum packet is 2^CNT_W−1 = 63 beats.
  - Comparisons are unsigned.
  - No wrap occurs within a packet; counters clear on `start`.

Optional Feature:
- Macro `FIFO_AXIS_READER_TUSER_EN`.
- When defined: adds output `m_axis_tuser` (1 bit) = tvalid & (`tx_cnt`=0), marking the first beat of each packet; it is held stable under backpressure and resets to 0.
- When undefined: the port is absent and there is no logic.

Test Plan:
- **Basic packet.** Reset 4 cycles; FIFO model preloaded with 3'o2,3'o1,3'o2,3'o1 (6'o12 written twice); `cntLimit`=4; `start` pulse; `tready`=1.
  - Exactly 4 `fifo_rd_en`.
  - tdata sequence 2,1,2,1 on consecutive cycles; tvalid first high 2 edges after `start`.
  - tlast on beat 4 only; `done` 1 cycle later; `busy` low after.
- **Backpressure.** `cntLimit`=6, 6 words in FIFO; `tready` toggles 1,0,0,1,…
  - No beat lost or duplicated; data and tlast stable during stalls.
  - Occupancy never exceeds 2; `fifo_rd_en` never asserted while the buffer is full.
- **Starvation.** `cntLimit`=5, FIFO holds 2 words, 3 more written 10 cycles later.
  - 2 beats, tvalid low gap, then 3 beats; tlast on beat 5.
  - `fifo_rd_en` never asserted while `fifo_empty`=1.
- **Boundaries.**
  - `start` with `cntLimit`=0 → no reads, no `done`.
  - `cntLimit`=63 with `tready`=1 → 63 beats back-to-back, single tlast.
  - `start` re-asserted during RUN is ignored.
- **Reset mid-packet.** `rst`=1 after beat 2 of 4 → next cycle all outputs 0 and state IDLE; a new `start` with `cntLimit`=2 transmits 2 fresh beats correctly.
- **TUSER build.** Same stimulus as Basic packet built with `FIFO_AXIS_READER_TUSER_EN` → tuser=1 on beat 1 only.
